// File: rtl/ccsds_turbo_enc_pingpong_pkg.sv
// Shared types and sizing for the CCSDS turbo encoder ping-pong frame buffer.
// Bank lifecycle states, default frame length and address-width derivation.
package ccsds_turbo_enc_pingpong_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_t;

  localparam int K_DEFAULT = 8160;

  function automatic int addr_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/ccsds_turbo_bitram.sv
// Simple dual-port bit RAM holding both frame banks; the bank index is the address MSB.
// Registered read, no reset, so it maps onto block RAM.
module ccsds_turbo_bitram #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic          wdata,
  input  logic [AW:0]   raddr,
  output logic          q
);

  // Each bank spans a full power-of-two window so {bank,addr} needs no adder.
  logic mem [0:(2 << AW) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    q <= mem[raddr];
  end

endmodule

// File: rtl/ccsds_turbo_enc_pingpong.sv
// Two-bank ping-pong input buffer between the encoder FIFO and the turbo encoder core.
// Optional sticky protocol error output enabled by macro CCSDS_TURBO_PP_ERRCHK_EN.
module ccsds_turbo_enc_pingpong
  import ccsds_turbo_enc_pingpong_pkg::*;
#(
  parameter  int K  = K_DEFAULT,
  localparam int AW = addr_width(K)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_data,
  input  logic          i_data_valid,
  output logic          o_ram_busy,
  output logic          o_frame_ready,
  output logic          o_rd_bank,
  input  logic          i_rd_start,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rd_data,
  input  logic          i_rd_done,
  output logic          o_err
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(K - 1);
  localparam logic [AW:0]   K_LIMIT   = (AW + 1)'(K);

  bank_state_t   bank_reg  [2];
  bank_state_t   bank_next [2];
  logic [AW-1:0] wr_cnt_reg, wr_cnt_next;
  logic          wr_sel_reg, wr_sel_next;
  logic          last_done_reg, last_done_next;
  logic          busy_reg;
  logic          rd_ok_reg;

  logic filling_any, fill_bank, reading_any, read_bank;
  logic full_any, head_bank, can_write, wr_bank, wr_en, ram_q;

  always_comb begin
    filling_any = (bank_reg[0] == BANK_FILLING) || (bank_reg[1] == BANK_FILLING);
    fill_bank   = (bank_reg[1] == BANK_FILLING);
    reading_any = (bank_reg[0] == BANK_READING) || (bank_reg[1] == BANK_READING);
    read_bank   = (bank_reg[1] == BANK_READING);
    full_any    = (bank_reg[0] == BANK_FULL) || (bank_reg[1] == BANK_FULL);
    // With both banks full, the older one is the one not completed most recently.
    if ((bank_reg[0] == BANK_FULL) && (bank_reg[1] == BANK_FULL)) begin
      head_bank = ~last_done_reg;
    end else begin
      head_bank = (bank_reg[1] == BANK_FULL);
    end
  end

  always_comb begin
    can_write = 1'b1;
    wr_bank   = wr_sel_reg;
    if (filling_any) begin
      wr_bank = fill_bank;
    end else if (bank_reg[wr_sel_reg] == BANK_EMPTY) begin
      wr_bank = wr_sel_reg;
    end else if (bank_reg[~wr_sel_reg] == BANK_EMPTY) begin
      wr_bank = ~wr_sel_reg;
    end else begin
      can_write = 1'b0;
    end
  end

  assign wr_en         = i_data_valid && can_write;
  assign o_frame_ready = full_any && !reading_any;
  assign o_rd_bank     = reading_any ? read_bank : head_bank;

  // Release uses the pre-edge state, so a bank freed this edge is only fillable next edge.
  always_comb begin
    bank_next[0]   = bank_reg[0];
    bank_next[1]   = bank_reg[1];
    wr_cnt_next    = wr_cnt_reg;
    wr_sel_next    = wr_sel_reg;
    last_done_next = last_done_reg;
    if (wr_en) begin
      if (wr_cnt_reg == LAST_ADDR) begin
        bank_next[wr_bank] = BANK_FULL;
        wr_cnt_next        = '0;
        last_done_next     = wr_bank;
      end else begin
        bank_next[wr_bank] = BANK_FILLING;
        wr_cnt_next        = wr_cnt_reg + AW'(1);
      end
      if (!filling_any) begin
        wr_sel_next = ~wr_bank;
      end
    end
    if (i_rd_start && o_frame_ready) begin
      bank_next[head_bank] = BANK_READING;
    end
    if (i_rd_done && reading_any) begin
      bank_next[read_bank] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        bank_reg[i] <= BANK_EMPTY;
      end
      wr_cnt_reg    <= '0;
      wr_sel_reg    <= 1'b0;
      last_done_reg <= 1'b0;
      busy_reg      <= 1'b0;
      rd_ok_reg     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bank_reg[i] <= bank_next[i];
      end
      wr_cnt_reg    <= wr_cnt_next;
      wr_sel_reg    <= wr_sel_next;
      last_done_reg <= last_done_next;
      busy_reg      <= (bank_reg[0] != BANK_EMPTY) && (bank_reg[1] != BANK_EMPTY);
      rd_ok_reg     <= reading_any && ({1'b0, i_rd_addr} < K_LIMIT);
    end
  end

  assign o_ram_busy = busy_reg;

  ccsds_turbo_bitram #(
    .AW (AW)
  ) u_bitram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_bank, wr_cnt_reg}),
    .wdata (i_data),
    .raddr ({read_bank, i_rd_addr}),
    .q     (ram_q)
  );

  // Gate flag forces 0 after reset, outside a read, or for addresses past the frame.
  assign o_rd_data = ram_q & rd_ok_reg;

`ifdef CCSDS_TURBO_PP_ERRCHK_EN
  logic err_reg;
  logic proto_err;

  assign proto_err = (i_data_valid && !can_write) ||
                     (i_rd_start && !o_frame_ready) ||
                     (i_rd_done && !reading_any);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_reg <= 1'b0;
    end else if (proto_err) begin
      err_reg <= 1'b1;
    end
  end

  assign o_err = err_reg;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_ccsds_turbo_enc_pingpong.sv
// Directed bench for the ping-pong frame buffer: K=16 protocol sequence plus a K=8160 mid-frame reset.
// Expected o_err follows CCSDS_TURBO_PP_ERRCHK_EN.
module tb_ccsds_turbo_enc_pingpong;

`ifdef CCSDS_TURBO_PP_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       a_rstn, a_data, a_valid, a_rd_start, a_rd_done;
  logic [3:0] a_rd_addr;
  logic       a_busy, a_ready, a_rd_bank, a_rd_data, a_err;

  logic        b_rstn, b_data, b_valid, b_rd_start, b_rd_done;
  logic [12:0] b_rd_addr;
  logic        b_busy, b_ready, b_rd_bank, b_rd_data, b_err;

  ccsds_turbo_enc_pingpong #(.K(16)) dut_a (
    .clk(clk), .rstn(a_rstn), .i_data(a_data), .i_data_valid(a_valid),
    .o_ram_busy(a_busy), .o_frame_ready(a_ready), .o_rd_bank(a_rd_bank),
    .i_rd_start(a_rd_start), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data),
    .i_rd_done(a_rd_done), .o_err(a_err)
  );

  ccsds_turbo_enc_pingpong #(.K(8160)) dut_b (
    .clk(clk), .rstn(b_rstn), .i_data(b_data), .i_data_valid(b_valid),
    .o_ram_busy(b_busy), .o_frame_ready(b_ready), .o_rd_bank(b_rd_bank),
    .i_rd_start(b_rd_start), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
    .i_rd_done(b_rd_done), .o_err(b_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // MSB first, so frame bit 15-i lands at address i; optional 2-cycle gap before bit gap_at.
  task automatic send16(input logic [15:0] w, input int gap_at);
    for (int i = 0; i < 16; i++) begin
      if (gap_at > 0 && i == gap_at) begin
        a_valid = 1'b0;
        tick();
        tick();
      end
      a_data  = w[15-i];
      a_valid = 1'b1;
      tick();
    end
    a_valid = 1'b0;
    a_data  = 1'b0;
  endtask

  task automatic read16(input string tag, input logic exp_bank, input logic [15:0] w, input bit do_done);
    check_eq({tag, "_ready"}, 32'(a_ready), 32'd1);
    check_eq({tag, "_bank"}, 32'(a_rd_bank), 32'(exp_bank));
    a_rd_start = 1'b1;
    tick();
    a_rd_start = 1'b0;
    check_eq({tag, "_ready_drop"}, 32'(a_ready), 32'd0);
    for (int a = 15; a >= 0; a--) begin
      a_rd_addr = 4'(a);
      tick();
      check_eq($sformatf("%s_bit%0d", tag, a), 32'(a_rd_data), 32'(w[15-a]));
    end
    if (do_done) begin
      a_rd_done = 1'b1;
      tick();
      a_rd_done = 1'b0;
    end
  endtask

  function automatic logic pat_a(input int i);
    return i[0];
  endfunction
  function automatic logic pat_b(input int i);
    return ~i[1];
  endfunction
  function automatic logic pat_c(input int i);
    return (i % 3) == 0;
  endfunction

  task automatic check_b_reset(input string tag);
    check_eq({tag, "_busy"}, 32'(b_busy), 32'd0);
    check_eq({tag, "_ready"}, 32'(b_ready), 32'd0);
    check_eq({tag, "_bank"}, 32'(b_rd_bank), 32'd0);
    check_eq({tag, "_data"}, 32'(b_rd_data), 32'd0);
    check_eq({tag, "_err"}, 32'(b_err), 32'd0);
  endtask

  initial begin
    a_rstn = 0; a_data = 0; a_valid = 0; a_rd_start = 0; a_rd_done = 0; a_rd_addr = 0;
    b_rstn = 0; b_data = 0; b_valid = 0; b_rd_start = 0; b_rd_done = 0; b_rd_addr = 0;
    repeat (3) tick();

    check_eq("rst_busy", 32'(a_busy), 32'd0);
    check_eq("rst_ready", 32'(a_ready), 32'd0);
    check_eq("rst_bank", 32'(a_rd_bank), 32'd0);
    check_eq("rst_data", 32'(a_rd_data), 32'd0);
    check_eq("rst_err", 32'(a_err), 32'd0);
    a_rstn = 1; b_rstn = 1;
    tick();

    // Stray start with nothing offered
    a_rd_start = 1'b1;
    tick();
    a_rd_start = 1'b0;
    check_eq("stray_start_ready", 32'(a_ready), 32'd0);
    check_eq("stray_start_busy", 32'(a_busy), 32'd0);
    check_eq("stray_start_err", 32'(a_err), 32'(ERR_EXP));
    a_rstn = 1'b0;
    #1;
    check_eq("err_cleared_by_reset", 32'(a_err), 32'd0);
    tick();
    a_rstn = 1'b1;
    tick();

    send16(16'hA5C3, 0);
    check_eq("f0_ready", 32'(a_ready), 32'd1);
    check_eq("f0_bank", 32'(a_rd_bank), 32'd0);
    check_eq("f0_busy", 32'(a_busy), 32'd0);
    check_eq("f0_err", 32'(a_err), 32'd0);

    send16(16'h3C96, 8);
    check_eq("f1_busy", 32'(a_busy), 32'd1);
    check_eq("f1_ready", 32'(a_ready), 32'd1);
    check_eq("f1_bank", 32'(a_rd_bank), 32'd0);

    a_data = 1'b1; a_valid = 1'b1;
    tick();
    a_valid = 1'b0; a_data = 1'b0;
    check_eq("drop33_err", 32'(a_err), 32'(ERR_EXP));
    check_eq("drop33_busy", 32'(a_busy), 32'd1);

    read16("rd0", 1'b0, 16'hA5C3, 1'b0);
    a_rd_done = 1'b1;
    tick();
    a_rd_done = 1'b0;
    check_eq("done0_busy_e1", 32'(a_busy), 32'd1);
    check_eq("done0_ready", 32'(a_ready), 32'd1);
    check_eq("done0_bank", 32'(a_rd_bank), 32'd1);
    tick();
    check_eq("done0_busy_e2", 32'(a_busy), 32'd0);

    read16("rd1", 1'b1, 16'h3C96, 1'b0);
    send16(16'h1234, 0);
    check_eq("f2_ready", 32'(a_ready), 32'd0);
    check_eq("f2_bank", 32'(a_rd_bank), 32'd1);
    check_eq("f2_busy", 32'(a_busy), 32'd1);

    // Release and new bit on the same edge: the freed bank is not yet selectable
    a_rd_done = 1'b1; a_valid = 1'b1; a_data = 1'b1;
    tick();
    a_rd_done = 1'b0; a_valid = 1'b0; a_data = 1'b0;
    send16(16'h0F0F, 0);
    check_eq("f3_ready", 32'(a_ready), 32'd1);
    check_eq("f3_bank", 32'(a_rd_bank), 32'd0);
    check_eq("f3_busy", 32'(a_busy), 32'd1);
    read16("rd2", 1'b0, 16'h1234, 1'b1);
    read16("rd3", 1'b1, 16'h0F0F, 1'b1);
    tick();
    check_eq("idle_busy", 32'(a_busy), 32'd0);
    check_eq("idle_ready", 32'(a_ready), 32'd0);

    // K=8160: full frame, read in progress, second frame interrupted at bit 4000
    for (int i = 0; i < 8160; i++) begin
      b_data = pat_a(i); b_valid = 1'b1;
      tick();
    end
    b_valid = 1'b0;
    check_eq("big_f0_ready", 32'(b_ready), 32'd1);
    check_eq("big_f0_busy", 32'(b_busy), 32'd0);
    b_rd_start = 1'b1;
    tick();
    b_rd_start = 1'b0;
    b_rd_addr  = 13'd1;
    for (int i = 0; i < 4000; i++) begin
      b_data = pat_b(i); b_valid = 1'b1;
      tick();
    end
    b_valid = 1'b0;
    check_eq("big_pre_busy", 32'(b_busy), 32'd1);
    check_eq("big_pre_data", 32'(b_rd_data), 32'(pat_a(1)));
    b_rstn = 1'b0;
    #1;
    check_b_reset("big_rst");
    tick();
    b_rstn = 1'b1;
    b_rd_addr = 13'd0;
    tick();

    for (int i = 0; i < 8160; i++) begin
      b_data = pat_c(i); b_valid = 1'b1;
      tick();
    end
    b_valid = 1'b0;
    check_eq("big_f1_ready", 32'(b_ready), 32'd1);
    check_eq("big_f1_bank", 32'(b_rd_bank), 32'd0);
    b_rd_start = 1'b1;
    tick();
    b_rd_start = 1'b0;
    begin
      int addrs [5];
      addrs = '{0, 3, 3999, 8159, 8160};
      for (int j = 0; j < 5; j++) begin
        b_rd_addr = 13'(addrs[j]);
        tick();
        check_eq($sformatf("big_rd_addr%0d", addrs[j]), 32'(b_rd_data),
                 (addrs[j] < 8160) ? 32'(pat_c(addrs[j])) : 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccsds_turbo_enc_pingpong.md
CCSDS_TURBO_ENC_PINGPONG -- requirements
Module: ccsds_turbo_enc_pingpong

Interface
REQ-001 SHALL have parameter K, default 8160, information bits per frame; AW = $clog2(K) address width.
REQ-002 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_data  input  1  serial frame bit from the encoder input FIFO.
REQ-005 SHALL have port i_data_valid  input  1  i_data qualifier; frames arrive as K-bit bursts, possibly gapped.
REQ-006 SHALL have port o_ram_busy  output  1  no bank free to accept a new frame; drives the FIFO's i_ram_busy.
REQ-007 SHALL have port o_frame_ready  output  1  a FULL bank is waiting for the encoder core.
REQ-008 SHALL have port o_rd_bank  output  1  bank index offered or being read.
REQ-009 SHALL have port i_rd_start  input  1  pulse, core claims the offered bank.
REQ-010 SHALL have port i_rd_addr  input  AW  bit address, natural or interleaved order.
REQ-011 SHALL have port o_rd_data  output  1  bit at i_rd_addr of the READING bank.
REQ-012 SHALL have port i_rd_done  input  1  pulse, core releases the READING bank.
REQ-013 SHALL have port o_err  output  1  sticky protocol error (see REQ-030).

Function
REQ-014 SHALL hold two K-bit banks, each with state EMPTY, FILLING, FULL or READING.
REQ-015 On i_data_valid with no FILLING bank, SHALL pick the write bank (bank 0 first after reset, then alternate; if the alternate bank is not EMPTY, the other EMPTY bank), mark it FILLING, and store the bit at address 0.
REQ-016 SHALL store each valid bit at wr_cnt, wr_cnt incrementing 0..K-1; at K-1 bank goes FULL and wr_cnt returns to 0 in the same edge.
REQ-017 o_ram_busy SHALL be registered, 1 when no bank is EMPTY (FILLING counts as occupied).
REQ-018 o_frame_ready SHALL be 1 while the oldest completed bank is FULL and no bank is READING; o_rd_bank points at it.
REQ-019 i_rd_start while o_frame_ready SHALL move that bank FULL->READING next edge; o_frame_ready drops same edge.
REQ-020 o_rd_data SHALL be registered, 1-cycle latency from i_rd_addr, reading the READING bank; i_rd_addr >= K returns 0.
REQ-021 i_rd_done SHALL move the READING bank to EMPTY next edge; o_ram_busy updates one edge later.
REQ-022 Banks SHALL be consumed in fill order.
REQ-023 i_rd_start with o_frame_ready=0, or i_rd_done with no READING bank: ignored.
REQ-024 i_rd_done and i_data_valid on the same edge targeting the released bank: release first; the fill selects it no earlier than the following edge, the bit being dropped per REQ-026 only if no other bank is EMPTY.
REQ-025 Simultaneous fill completion and i_rd_start on different banks SHALL both take effect.
REQ-026 i_data_valid with no EMPTY/FILLING bank SHALL drop the bit, wr_cnt unchanged.

Reset
REQ-027 On rstn low SHALL asynchronously force: both banks EMPTY, wr_cnt 0, write-select 0, o_ram_busy 0, o_frame_ready 0, o_rd_bank 0, o_rd_data 0, o_err 0.
REQ-028 Reset mid-frame SHALL discard partial and stored frames; bank contents need not be cleared.

Configuration
REQ-029 Macro CCSDS_TURBO_PP_ERRCHK_EN SHALL gate error checking.
REQ-030 Defined: o_err sets on dropped bit (REQ-026) or ignored rd pulse (REQ-023), clears only on reset; undefined: o_err tied 0, behaviour otherwise identical.

Structure
REQ-031 Shared package SHALL hold the bank-state enumeration, default K, and the AW derivation.
REQ-032 Bank storage SHALL be sub-module ccsds_turbo_bitram: simple dual-port 2K x 1 RAM, write port {bank,wr_cnt}, registered read port {bank,i_rd_addr}.

Verification
REQ-033 K=16: one 16-bit burst 0xA5C3 -> bank 0 FULL, o_frame_ready=1, o_rd_bank=0, o_ram_busy=0.
REQ-034 K=16: two bursts, no read -> o_ram_busy=1 one edge after 32nd bit; 33rd valid bit dropped, o_err=1 with macro, 0 without.
REQ-035 K=16: i_rd_start, sweep i_rd_addr 15..0 -> o_rd_data returns bit-reversed frame, each 1 cycle after address.
REQ-036 K=16: i_rd_done on bank 0 while bank 1 FULL -> o_ram_busy=0 two edges later, o_rd_bank=1, o_frame_ready=1.
REQ-037 K=8160: rstn low at bit 4000 of frame 1 -> all outputs reset values; next full burst lands in bank 0 at address 0.
REQ-038 K=16: i_rd_start with o_frame_ready=0 -> no state change, o_err=1 with macro.
